// File: rtl/frame_fill_engine.sv
// frame_fill_engine: paints one frame buffer with a single colour by streaming
// 8-pixel bursts (one address entry + two identical write-data entries) into
// the DRAM request controller's af/wdf FIFOs.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | FF_ready high, waiting for a fill request
//   S_BURST_A | push burst address and first data beat together
//   S_BURST_B | push second data beat, then advance x/y or finish
module frame_fill_engine #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         FF_valid,
  input  logic [23:0]  FF_color,
  input  logic [31:0]  FF_frame,
  output logic         FF_ready,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST_A = 2'd1,
    S_BURST_B = 2'd2
  } state_t;

  localparam logic [9:0] X_LAST = 10'(WIDTH - 8);
  localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

  state_t      state, state_nx;
  logic [9:0]  x, y, x_nx, y_nx;
  logic [23:0] colour_q;
  // Only the 4 MB frame index bits inside the 256 MB DRAM window reach the address.
  logic [5:0]  frame_q;
  logic        accept;

  // Frame bits outside the DRAM window and the aligned low bits never matter.
  logic unused_frame_bits;
  assign unused_frame_bits = ^{FF_frame[31:28], FF_frame[21:0]};

  assign accept = FF_valid && (state == S_IDLE);

  // State, pixel counters and the latched request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      x        <= '0;
      y        <= '0;
      colour_q <= '0;
      frame_q  <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      if (accept) begin
        colour_q <= FF_color;
        frame_q  <= FF_frame[27:22];
      end
    end
  end

  // Next-state, counter stepping and FIFO push enables.
  always_comb begin
    state_nx  = state;
    x_nx      = x;
    y_nx      = y;
    FF_ready  = 1'b0;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;
    case (state)
      S_IDLE: begin
        FF_ready = 1'b1;
        if (FF_valid) begin
          state_nx = S_BURST_A;
          x_nx     = '0;
          y_nx     = '0;
        end
      end
      S_BURST_A: begin
        // Address and first beat go together so a burst is never split by af_full.
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          state_nx  = S_BURST_A == S_BURST_A ? S_BURST_B : S_BURST_B;
        end
      end
      S_BURST_B: begin
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          if (x == X_LAST) begin
            if (y == Y_LAST) begin
              state_nx = S_IDLE;
            end else begin
              x_nx     = '0;
              y_nx     = y + 10'd1;
              state_nx = S_BURST_A;
            end
          end else begin
            x_nx     = x + 10'd8;
            state_nx = S_BURST_A;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign af_addr_din  = {6'b0, frame_q, y, x[9:3], 2'b00};
  assign wdf_din      = {4{8'h00, colour_q}};
  assign wdf_mask_din = 16'h0000;

endmodule

// File: tb/tb_frame_fill_engine.sv
// Bench for frame_fill_engine with a 16x2 frame. A queue model expands each
// accepted request into its burst address / data stream from the pixel address
// formula; DUT pushes are popped and compared on every negative edge.
module tb_frame_fill_engine;
  localparam int W = 16;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         FF_valid = 1'b0;
  logic [23:0]  FF_color = '0;
  logic [31:0]  FF_frame = '0;
  logic         FF_ready;
  logic         af_full = 1'b0;
  logic         wdf_full = 1'b0;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;

  frame_fill_engine #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .FF_valid(FF_valid), .FF_color(FF_color),
    .FF_frame(FF_frame), .FF_ready(FF_ready), .af_full(af_full),
    .wdf_full(wdf_full), .af_wr_en(af_wr_en), .af_addr_din(af_addr_din),
    .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  function automatic void check(bit ok, string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endfunction

  // Model state
  logic [30:0]  af_q[$];
  logic [127:0] wdf_q[$];
  logic [30:0]  af_seen[$];
  int           wdf_seen = 0;
  logic [127:0] wdf_last = '0;
  bit           exp_ready = 1'b1;
  bit           chk_en = 1'b0;

  // Model: expand an accepted request into its full expected write stream.
  always @(posedge clk) begin
    if (rst) begin
      af_q.delete();
      wdf_q.delete();
    end else if (chk_en && FF_valid && exp_ready) begin
      for (int yy = 0; yy < H; yy++) begin
        for (int xx = 0; xx < W; xx += 8) begin
          logic [31:0] pix;
          pix = {FF_frame[31:22], 10'(yy), 10'(xx), 2'b00};
          af_q.push_back({6'b0, pix[27:3]});
          wdf_q.push_back({4{8'h00, FF_color}});
          wdf_q.push_back({4{8'h00, FF_color}});
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [30:0]  ea;
      logic [127:0] ed;
      exp_ready = (wdf_q.size() == 0);
      check(FF_ready == exp_ready, "ff_ready", FF_ready, exp_ready);
      check(wdf_mask_din == 16'h0, "wdf_mask", wdf_mask_din, 0);
      check(!(af_wr_en && af_full) && !(wdf_wr_en && wdf_full), "push_when_full",
            {af_wr_en, af_full, wdf_wr_en, wdf_full}, 0);
      if (af_wr_en) begin
        if (af_q.size() == 0) check(1'b0, "af_extra", af_addr_din, 0);
        else begin
          ea = af_q.pop_front();
          check(af_addr_din == ea, "af_addr", af_addr_din, ea);
          af_seen.push_back(af_addr_din);
        end
      end
      if (wdf_wr_en) begin
        if (wdf_q.size() == 0) check(1'b0, "wdf_extra", wdf_din, 0);
        else begin
          ed = wdf_q.pop_front();
          check(wdf_din == ed, "wdf_data", wdf_din, ed);
          wdf_seen++;
          wdf_last = wdf_din;
        end
      end
    end
  end

  task automatic accept(input logic [31:0] frame, input logic [23:0] col);
    FF_frame = frame;
    FF_color = col;
    FF_valid = 1'b1;
    @(posedge clk); #1;
    FF_valid = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns the cycle in which FF_ready is seen.
  task automatic wait_done(input int af_stall, input int wdf_stall, input int mid_req,
                           output int n);
    n = 1;
    forever begin
      af_full  = (n <= af_stall);
      wdf_full = (n >= 2) && (n < 2 + wdf_stall);
      if (mid_req != 0 && n == mid_req) begin
        FF_valid = 1'b1;
        FF_color = 24'h00ff00;
      end
      @(posedge clk); #1;
      n++;
      if (FF_ready) break;
      if (n > 400) begin
        check(1'b0, "ready_timeout", n, 0);
        break;
      end
    end
    af_full  = 1'b0;
    wdf_full = 1'b0;
  endtask

  logic [30:0] lit_af[4];
  int n;

  initial begin
    lit_af[0] = 31'h0008_0000;
    lit_af[1] = 31'h0008_0004;
    lit_af[2] = 31'h0008_0200;
    lit_af[3] = 31'h0008_0204;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check(FF_ready == 1'b1, "rst_ready", FF_ready, 1);
    check(af_wr_en == 1'b0, "rst_af_en", af_wr_en, 0);
    check(wdf_wr_en == 1'b0, "rst_wdf_en", wdf_wr_en, 0);
    check(wdf_mask_din == 16'h0, "rst_mask", wdf_mask_din, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fill, pinned by literal addresses and data
    af_seen.delete(); wdf_seen = 0;
    accept(32'h1040_0000, 24'hff0000);
    wait_done(0, 0, 0, n);
    check(n == 9, "fill_cycles", n, 9);
    check(af_seen.size() == 4, "af_count", af_seen.size(), 4);
    for (int i = 0; i < 4; i++)
      check((i < af_seen.size()) && (af_seen[i] == lit_af[i]), "af_literal",
            (i < af_seen.size()) ? af_seen[i] : 31'h0, lit_af[i]);
    check(wdf_seen == 8, "wdf_count", wdf_seen, 8);
    check(wdf_last == 128'h00ff0000_00ff0000_00ff0000_00ff0000, "wdf_literal",
          wdf_last, 128'h00ff0000_00ff0000_00ff0000_00ff0000);

    // af_full stall of 5 cycles in BURST_A
    af_seen.delete(); wdf_seen = 0;
    accept(32'h20c0_0000, 24'h123456);
    wait_done(5, 0, 0, n);
    check(n == 14, "af_stall_cycles", n, 14);
    check(af_seen.size() == 4, "af_stall_count", af_seen.size(), 4);

    // wdf_full stall of 3 cycles in BURST_B
    af_seen.delete(); wdf_seen = 0;
    accept(32'h0000_0000, 24'h00aa55);
    wait_done(0, 3, 0, n);
    check(n == 12, "wdf_stall_cycles", n, 12);
    check(wdf_seen == 2 * af_seen.size() && af_seen.size() == 4, "wdf_per_af",
          wdf_seen, 8);

    // Second request mid-fill is ignored, then accepted once ready
    af_seen.delete(); wdf_seen = 0;
    accept(32'h0040_0000, 24'h0000ff);
    wait_done(0, 0, 3, n);
    check(n == 9, "busy_fill_cycles", n, 9);
    check(wdf_last == {4{32'h000000ff}}, "busy_colour", wdf_last, {4{32'h000000ff}});
    @(posedge clk); #1;
    FF_valid = 1'b0;
    wait_done(0, 0, 0, n);
    check(n == 9, "second_fill_cycles", n, 9);
    check(wdf_last == {4{32'h0000ff00}}, "second_colour", wdf_last, {4{32'h0000ff00}});

    // Reset in BURST_B mid-fill, then a fresh request restarts at x=y=0
    accept(32'h0080_0000, 24'habcdef);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check(FF_ready == 1'b1, "midrst_ready", FF_ready, 1);
    check(af_wr_en == 1'b0 && wdf_wr_en == 1'b0, "midrst_en", {af_wr_en, wdf_wr_en}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    af_seen.delete(); wdf_seen = 0;
    accept(32'h0080_0000, 24'h0f0f0f);
    wait_done(0, 0, 0, n);
    check(n == 9, "restart_cycles", n, 9);
    check((af_seen.size() > 0) && (af_seen[0] == 31'h0010_0000), "restart_addr",
          (af_seen.size() > 0) ? af_seen[0] : 31'h0, 31'h0010_0000);

    repeat (3) @(posedge clk);
    #1;
    check(af_q.size() == 0 && wdf_q.size() == 0, "model_drained",
          af_q.size() + wdf_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
